// File: rtl/run_sequencer.sv
// Run controller: holds DUT reset, issues the request, gathers per-channel done and counts run cycles.
// Optional RUN_SEQ_REQ_LEVEL_EN keeps req high through RUN instead of a one-cycle pulse.
module run_sequencer #(
    parameter int N_CH           = 1,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 20,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [N_CH-1:0]  ch_en,
    input  logic [N_CH-1:0]  done_in,
    output logic             dut_reset,
    output logic             req,
    output logic             busy,
    output logic             finished,
    output logic             timed_out,
    output logic [N_CH-1:0]  done_seen,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_HOLD,
        S_REQ,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t          state, state_n;
    logic [HW-1:0]   hold_cnt;
    logic [N_CH-1:0] en_q;
    logic            all_done;
    logic            tmo_hit;

    // The current cycle's done_in counts, so a channel finishing now completes the run now.
    assign all_done = ((done_seen | done_in) & en_q) == en_q;
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (cycle_count == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_TIMEOUT: if (start) state_n = S_RST_HOLD;
                S_RST_HOLD: if (hold_cnt == '0) state_n = S_REQ;
                S_REQ:      state_n = S_RUN;
                S_RUN: begin
                    if (all_done)     state_n = S_DONE;
                    else if (tmo_hit) state_n = S_TIMEOUT;
                end
                default:    state_n = S_IDLE;
            endcase
        end
    end

    // Datapath; abort freezes done_seen and cycle_count for inspection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt    <= '0;
            en_q        <= '0;
            done_seen   <= '0;
            cycle_count <= '0;
        end else if (!abort) begin
            case (state)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (start) begin
                        en_q        <= ch_en;
                        done_seen   <= '0;
                        cycle_count <= '0;
                        hold_cnt    <= HW'(RST_CYCLES);
                    end
                end
                S_RST_HOLD: begin
                    if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
                end
                S_RUN: begin
                    done_seen <= done_seen | (done_in & en_q);
                    if (state_n == S_RUN && cycle_count != '1)
                        cycle_count <= cycle_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dut_reset <= 1'b1;
            req       <= 1'b0;
            busy      <= 1'b0;
            finished  <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            dut_reset <= (state_n == S_IDLE) || (state_n == S_RST_HOLD);
`ifdef RUN_SEQ_REQ_LEVEL_EN
            req       <= (state_n == S_REQ) || (state_n == S_RUN);
`else
            req       <= (state_n == S_REQ);
`endif
            busy      <= (state_n == S_RST_HOLD) || (state_n == S_REQ) || (state_n == S_RUN);
            finished  <= (state_n == S_DONE) || (state_n == S_TIMEOUT);
            timed_out <= (state_n == S_TIMEOUT);
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench for run_sequencer; expectations come from a per-run outcome model.
module tb_run_sequencer;

    localparam int NCH = 4;
    localparam int R   = 2;
    localparam int T   = 20;
    localparam int CW  = 16;
`ifdef RUN_SEQ_REQ_LEVEL_EN
    localparam logic LVL = 1'b1;
`else
    localparam logic LVL = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset, start, abort;
    logic [NCH-1:0] ch_en, done_in;
    logic           dut_reset, req, busy, finished, timed_out;
    logic [NCH-1:0] done_seen;
    logic [CW-1:0]  cycle_count;

    int n_tests = 0;
    int n_fail  = 0;
    int s[4];

    run_sequencer #(.N_CH(NCH), .RST_CYCLES(R), .TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .ch_en(ch_en), .done_in(done_in),
        .dut_reset(dut_reset), .req(req), .busy(busy), .finished(finished),
        .timed_out(timed_out), .done_seen(done_seen), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One run: enabled channel c pulses done at RUN index sched[c] (>=T means never).
    // Expected end index is the last enabled pulse, or T-1 if any enabled channel misses the budget.
    task automatic run_one(input logic [3:0] en, input int sched[4], input int abort_at,
                           input bit busy_start);
        int e, dmax, ab;
        bit to, ended;
        logic [3:0] seen;
        dmax = 0;
        for (int c = 0; c < NCH; c++)
            if (en[c] && sched[c] > dmax) dmax = sched[c];
        if (en == 4'b0)      begin e = 0;     to = 1'b0; end
        else if (dmax < T)   begin e = dmax;  to = 1'b0; end
        else                 begin e = T - 1; to = 1'b1; end
        ab = (abort_at >= 0 && abort_at < e) ? abort_at : -1;
        seen = '0;
        for (int c = 0; c < NCH; c++)
            if (en[c] && (ab >= 0 ? sched[c] < ab : sched[c] <= e)) seen[c] = 1'b1;

        start = 1'b1; ch_en = en;
        tick();
        start = 1'b0; ch_en = 4'($urandom);
        check("start_busy", busy, 1);
        check("start_dut_reset", dut_reset, 1);
        check("start_seen_clr", done_seen, 0);
        check("start_cnt_clr", cycle_count, 0);
        for (int i = 1; i <= R; i++) begin
            done_in = 4'($urandom);
            tick();
            check("hold_req", req, 0);
            check("hold_dut_reset", dut_reset, 1);
        end
        done_in = 4'($urandom);
        tick();
        check("req_rise", req, 1);
        check("req_dut_reset", dut_reset, 0);
        done_in = 4'($urandom);
        tick();
        ended = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            check("run_req", req, LVL);
            check("run_busy", busy, 1);
            check("run_finished", finished, 0);
            check("run_cnt", cycle_count, k);
            for (int c = 0; c < NCH; c++)
                done_in[c] = en[c] ? (sched[c] == k) : 1'($urandom);
            abort = (k == ab);
            start = busy_start && (k == 1);
            tick();
            abort = 1'b0; start = 1'b0; done_in = '0;
            if (k == ab) begin
                check("abort_busy", busy, 0);
                check("abort_dut_reset", dut_reset, 1);
                check("abort_finished", finished, 0);
                check("abort_req", req, 0);
                check("abort_cnt", cycle_count, ab);
                check("abort_seen", done_seen, seen);
                return;
            end
            if (k == e) begin ended = 1'b1; break; end
        end
        if (!ended) check("run_bound", 0, 1);
        check("end_finished", finished, 1);
        check("end_timed_out", timed_out, to);
        check("end_busy", busy, 0);
        check("end_req", req, 0);
        check("end_cnt", cycle_count, e);
        check("end_seen", done_seen, seen);
        for (int i = 0; i < 2; i++) begin
            done_in = 4'($urandom);
            tick();
        end
        done_in = '0;
        check("hold_finished", finished, 1);
        check("hold_cnt", cycle_count, e);
        check("hold_seen", done_seen, seen);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dut_reset"}, dut_reset, 1);
        check({tag, "_req"}, req, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_finished"}, finished, 0);
        check({tag, "_timed_out"}, timed_out, 0);
        check({tag, "_seen"}, done_seen, 0);
        check({tag, "_cnt"}, cycle_count, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; ch_en = '0; done_in = '0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("rst");
        reset = 1'b0;
        tick();

        s = '{5, 99, 99, 99};   run_one(4'b0001, s, -1, 1'b0);
        s = '{99, 99, 99, 99};  run_one(4'b0001, s, -1, 1'b0);
        s = '{2, 9, 5, 4};      run_one(4'b1011, s, -1, 1'b0);
        s = '{3, 19, 7, 10};    run_one(4'b1111, s, -1, 1'b0);
        s = '{99, 99, 99, 99};  run_one(4'b0011, s, 7, 1'b0);
        s = '{4, 6, 99, 99};    run_one(4'b0011, s, -1, 1'b0);
        s = '{1, 1, 1, 1};      run_one(4'b0000, s, -1, 1'b0);
        s = '{3, 8, 2, 6};      run_one(4'b1101, s, -1, 1'b1);

        // Asynchronous reset in the middle of a run.
        start = 1'b1; ch_en = 4'b1111;
        tick();
        start = 1'b0;
        repeat (R + 7) tick();
        check("mid_busy", busy, 1);
        #2 reset = 1'b1;
        #1 check_reset_vals("async");
        #2 reset = 1'b0;
        tick();
        check("async_idle_busy", busy, 0);
        s = '{0, 2, 1, 3};      run_one(4'b1111, s, -1, 1'b0);

        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < NCH; c++)
                s[c] = ($urandom_range(0, 3) == 0) ? 99 : int'($urandom_range(0, 23));
            run_one(4'($urandom), s,
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1,
                    1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
